// File: rtl/multicycle_decode.sv
// Multicycle ARM control-unit front end: main FSM plus instruction/ALU decode.
// Every output is combinational from the current state and the Op/Funct/Rd fields.
// Write-type requests are gated by reset, so they drop as soon as reset is asserted.
module multicycle_decode (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       PCS,
    output logic [1:0] FlagW
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRd    = 4'd3,
        StMemWb    = 4'd4,
        StMemWr    = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StUnknown  = 4'd10
    } state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic       w_irwrite;
    logic       w_nextpc;
    logic       w_regw;
    logic       w_memw;
    logic       w_branch;
    logic       w_aluop;
    logic       w_unknown;
    logic       w_cmd_valid;
    logic [1:0] w_alu_ctl;
    logic [1:0] w_flagw;

    // State register, asynchronously returned to FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and per-state datapath controls.
    always_comb begin
        w_state_next = StFetch;
        w_irwrite    = 1'b0;
        w_nextpc     = 1'b0;
        w_regw       = 1'b0;
        w_memw       = 1'b0;
        w_branch     = 1'b0;
        w_aluop      = 1'b0;
        w_unknown    = 1'b0;
        AdrSrc       = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ResultSrc    = 2'b00;
        case (r_state)
            StFetch: begin
                w_irwrite    = 1'b1;
                w_nextpc     = 1'b1;
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                w_state_next = StDecode;
            end
            StDecode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   w_state_next = Funct[5] ? StExecuteI : StExecuteR;
                    2'b01:   w_state_next = StMemAdr;
                    2'b10:   w_state_next = StBranch;
                    default: w_state_next = StUnknown;
                endcase
            end
            StMemAdr: begin
                ALUSrcB      = 2'b01;
                w_state_next = Funct[0] ? StMemRd : StMemWr;
            end
            StMemRd: begin
                AdrSrc       = 1'b1;
                w_state_next = StMemWb;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                w_regw    = 1'b1;
            end
            StMemWr: begin
                AdrSrc = 1'b1;
                w_memw = 1'b1;
            end
            StExecuteR: begin
                w_aluop      = 1'b1;
                w_state_next = StAluWb;
            end
            StExecuteI: begin
                ALUSrcB      = 2'b01;
                w_aluop      = 1'b1;
                w_state_next = StAluWb;
            end
            StAluWb: begin
                w_regw = 1'b1;
            end
            StBranch: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_branch  = 1'b1;
            end
            // UNKNOWN and any illegal encoding: everything zero, back to FETCH.
            default: begin
                w_unknown = 1'b1;
            end
        endcase
    end

    // ALU decode; unsupported commands fall back to add with no flag update.
    always_comb begin
        w_alu_ctl   = 2'b00;
        w_cmd_valid = 1'b0;
        w_flagw     = 2'b00;
        if (w_aluop) begin
            w_cmd_valid = 1'b1;
            case (Funct[4:1])
                4'b0100: w_alu_ctl = 2'b00;
                4'b0010: w_alu_ctl = 2'b01;
                4'b0000: w_alu_ctl = 2'b10;
                4'b1100: w_alu_ctl = 2'b11;
                default: begin
                    w_alu_ctl   = 2'b00;
                    w_cmd_valid = 1'b0;
                end
            endcase
            if (w_cmd_valid) begin
                // C/V only meaningful for arithmetic (add/sub).
                w_flagw = {Funct[0], Funct[0] & ~w_alu_ctl[1]};
            end
        end
    end

    assign ALUControl = w_alu_ctl;
    assign ImmSrc     = w_unknown ? 2'b00 : Op;
    assign RegSrc     = w_unknown ? 2'b00 : {(Op == 2'b01), (Op == 2'b10)};

    // Requests are masked by reset directly so no partial write escapes mid-instruction.
    assign IRWrite = reset & w_irwrite;
    assign NextPC  = reset & w_nextpc;
    assign RegW    = reset & w_regw;
    assign MemW    = reset & w_memw;
    assign FlagW   = {2{reset}} & w_flagw;
    assign PCS     = reset & (((Rd == 4'b1111) & w_regw) | w_branch);

endmodule

// File: tb/tb_multicycle_decode.sv
// Scoreboard bench for multicycle_decode: stimulus pushes expected output vectors,
// a monitor pops and compares them on the falling edge.
module tb_multicycle_decode;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       PCS;
    logic [1:0] FlagW;

    typedef struct {
        string       name;
        logic [18:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    multicycle_decode dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .Rd        (Rd),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ImmSrc    (ImmSrc),
        .RegSrc    (RegSrc),
        .ALUControl(ALUControl),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .PCS       (PCS),
        .FlagW     (FlagW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: irw adr srca srcb res imm regsrc aluc npc regw memw pcs flagw
    function automatic logic [18:0] mk(input logic irw, input logic adr, input logic sa,
                                       input logic [1:0] sb, input logic [1:0] res,
                                       input logic [1:0] imm, input logic [1:0] rs,
                                       input logic [1:0] alu, input logic npc,
                                       input logic rw, input logic mw, input logic pcs,
                                       input logic [1:0] fw);
        return {irw, adr, sa, sb, res, imm, rs, alu, npc, rw, mw, pcs, fw};
    endfunction

    task automatic step(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                        input logic rst, input string nm, input logic [18:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        Op    = op;
        Funct = f;
        Rd    = rd;
        reset = rst;
        x.name = nm;
        x.v    = e;
        q.push_back(x);
    endtask

    // Monitor: every falling edge with a pending expectation is one comparison.
    initial begin
        exp_t        x;
        logic [18:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x   = q.pop_front();
                act = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
                       ALUControl, NextPC, RegW, MemW, PCS, FlagW};
                checks++;
                if (act !== x.v) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b (irw adr sa sb res imm rs alu npc rw mw pcs fw)",
                             x.name, act, x.v);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        Op    = 2'b01;
        Funct = 6'b011001;
        Rd    = 4'd3;
        #2 reset = 1'b0;

        // Reset held low for three cycles: gated FETCH values.
        for (int i = 0; i < 3; i++)
            step(2'b01, 6'b011001, 4'd3, 1'b0, "reset_gated",
                 mk(0, 0, 1, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 2'b00));

        // LDR r3
        step(2'b01, 6'b011001, 4'd3, 1'b1, "ldr_fetch",
             mk(1, 0, 1, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 1, 0, 0, 0, 2'b00));
        step(2'b01, 6'b011001, 4'd3, 1'b1, "ldr_decode",
             mk(0, 0, 1, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b01, 6'b011001, 4'd3, 1'b1, "ldr_memadr",
             mk(0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b01, 6'b011001, 4'd3, 1'b1, "ldr_memrd",
             mk(0, 1, 0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b01, 6'b011001, 4'd3, 1'b1, "ldr_memwb",
             mk(0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 0, 1, 0, 0, 2'b00));

        // STR
        step(2'b01, 6'b011000, 4'd5, 1'b1, "str_fetch",
             mk(1, 0, 1, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 1, 0, 0, 0, 2'b00));
        step(2'b01, 6'b011000, 4'd5, 1'b1, "str_decode",
             mk(0, 0, 1, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b01, 6'b011000, 4'd5, 1'b1, "str_memadr",
             mk(0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b01, 6'b011000, 4'd5, 1'b1, "str_memwr",
             mk(0, 1, 0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 2'b00));

        // ADDS register
        step(2'b00, 6'b001001, 4'd2, 1'b1, "adds_fetch",
             mk(1, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 2'b00));
        step(2'b00, 6'b001001, 4'd2, 1'b1, "adds_decode",
             mk(0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b00, 6'b001001, 4'd2, 1'b1, "adds_execr",
             mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11));
        step(2'b00, 6'b001001, 4'd2, 1'b1, "adds_aluwb",
             mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00));

        // ORRS immediate
        step(2'b00, 6'b111001, 4'd2, 1'b1, "orrs_fetch",
             mk(1, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 2'b00));
        step(2'b00, 6'b111001, 4'd2, 1'b1, "orrs_decode",
             mk(0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b00, 6'b111001, 4'd2, 1'b1, "orrs_execi",
             mk(0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 2'b10));
        step(2'b00, 6'b111001, 4'd2, 1'b1, "orrs_aluwb",
             mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00));

        // SUB to r15: PCS only in ALUWB
        step(2'b00, 6'b000100, 4'd15, 1'b1, "sub15_fetch",
             mk(1, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 2'b00));
        step(2'b00, 6'b000100, 4'd15, 1'b1, "sub15_decode",
             mk(0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b00, 6'b000100, 4'd15, 1'b1, "sub15_execr",
             mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 2'b00));
        step(2'b00, 6'b000100, 4'd15, 1'b1, "sub15_aluwb",
             mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 1, 2'b00));

        // Unsupported cmd (EOR) with S: add, no flag write
        step(2'b00, 6'b100011, 4'd4, 1'b1, "eor_fetch",
             mk(1, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 2'b00));
        step(2'b00, 6'b100011, 4'd4, 1'b1, "eor_decode",
             mk(0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b00, 6'b100011, 4'd4, 1'b1, "eor_execi",
             mk(0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b00, 6'b100011, 4'd4, 1'b1, "eor_aluwb",
             mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 2'b00));

        // B
        step(2'b10, 6'b101000, 4'd0, 1'b1, "b_fetch",
             mk(1, 0, 1, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 1, 0, 0, 0, 2'b00));
        step(2'b10, 6'b101000, 4'd0, 1'b1, "b_decode",
             mk(0, 0, 1, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b10, 6'b101000, 4'd0, 1'b1, "b_branch",
             mk(0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 0, 0, 0, 1, 2'b00));

        // Undefined Op=11
        step(2'b11, 6'b000000, 4'd0, 1'b1, "und_fetch",
             mk(1, 0, 1, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 1, 0, 0, 0, 2'b00));
        step(2'b11, 6'b000000, 4'd0, 1'b1, "und_decode",
             mk(0, 0, 1, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b11, 6'b000000, 4'd0, 1'b1, "und_unknown",
             mk(0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00));

        // LDR to r15 interrupted by reset in MEMRD, then rerun to completion
        step(2'b01, 6'b011001, 4'd15, 1'b1, "ldrr_fetch",
             mk(1, 0, 1, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 1, 0, 0, 0, 2'b00));
        step(2'b01, 6'b011001, 4'd15, 1'b1, "ldrr_decode",
             mk(0, 0, 1, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b01, 6'b011001, 4'd15, 1'b1, "ldrr_memadr",
             mk(0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b01, 6'b011001, 4'd15, 1'b0, "ldrr_rst_in_memrd",
             mk(0, 0, 1, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b01, 6'b011001, 4'd15, 1'b0, "ldrr_rst_hold",
             mk(0, 0, 1, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b01, 6'b011001, 4'd15, 1'b1, "ldrr_refetch",
             mk(1, 0, 1, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 1, 0, 0, 0, 2'b00));
        step(2'b01, 6'b011001, 4'd15, 1'b1, "ldrr_decode2",
             mk(0, 0, 1, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b01, 6'b011001, 4'd15, 1'b1, "ldrr_memadr2",
             mk(0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b01, 6'b011001, 4'd15, 1'b1, "ldrr_memrd2",
             mk(0, 1, 0, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 2'b00));
        step(2'b01, 6'b011001, 4'd15, 1'b1, "ldrr_memwb_pcs",
             mk(0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 0, 1, 0, 1, 2'b00));
        step(2'b00, 6'b001000, 4'd1, 1'b1, "final_fetch",
             mk(1, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 2'b00));

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
